// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub_pkg
// Brief    : Shared state encoding and default width for the serial subtractor.
// Revision : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

    localparam int unsigned c_default_width = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : full_subtractor
// Brief    : One-bit full subtractor, d = x - y - bin with borrow out.
// Revision : 1.0 - initial release
// ============================================================================
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial a - b - bin, LSB first, valid/ready on both sides.
//            Define SERIAL_SUB_OVF_EN to add the signed overflow output.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] difference,
`ifdef SERIAL_SUB_OVF_EN
    output logic             borrow,
    output logic             overflow
`else
    output logic             borrow
`endif
);

    localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_brw;
    logic [WIDTH-1:0]     r_diff;
    logic                 r_borrow;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_d;
    logic                 w_bout;

    full_subtractor u_fs (
        .x    (r_a[0]),
        .y    (r_b[0]),
        .bin  (r_brw),
        .d    (w_d),
        .bout (w_bout)
    );

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_cnt == c_cnt_w'(WIDTH - 1));

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = RUN;
            end
            RUN: begin
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The minuend register doubles as the result shift register: each consumed
    // a-bit frees the MSB slot that the new difference bit shifts into.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_brw    <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_brw <= bin;
                        r_cnt <= '0;
                    end
                end
                RUN: begin
                    r_a   <= {w_d, r_a[WIDTH-1:1]};
                    r_b   <= r_b >> 1;
                    r_brw <= w_bout;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_diff   <= {w_d, r_a[WIDTH-1:1]};
                        r_borrow <= w_bout;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (r_state == RUN && w_last) begin
            r_ovf <= r_brw ^ w_bout;
        end
    end

    assign overflow = r_ovf;
`endif

    assign difference = r_diff;
    assign borrow     = r_borrow;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Brief    : Self-checking bench for serial_subtractor (WIDTH=8) against an
//            arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] difference;
    logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic         overflow;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [W-1:0] prev_diff;
    logic         prev_brw;
    logic         prev_ovf;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .bin        (bin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .difference (difference),
`ifdef SERIAL_SUB_OVF_EN
        .borrow     (borrow),
        .overflow   (overflow)
`else
        .borrow     (borrow)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {overflow, borrow, difference} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic bi);
        int   ui = int'(x) - int'(y) - int'(bi);
        int   si = int'($signed(x)) - int'($signed(y)) - int'(bi);
        logic br = (int'(x) < int'(y) + int'(bi));
        logic ov = (si > 127) || (si < -128);
        return {ov, br, ui[W-1:0]};
    endfunction

    task automatic chk_ovf(input string tag, input logic exp);
`ifdef SERIAL_SUB_OVF_EN
        chk(tag, overflow, exp);
`endif
    endtask

    // Entered and left just after a falling edge.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tbin, input int hold);
        logic [W+1:0] e;
        int lat;
        e = model(ta, tb_v, tbin);
        chk("idle_in_ready", in_ready, 1);
        in_valid = 1'b1;
        a = ta; b = tb_v; bin = tbin;
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom);
        chk("run_in_ready_low", in_ready, 0);
        chk("run_keeps_old_diff", difference, prev_diff);
        chk("run_keeps_old_borrow", borrow, prev_brw);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, W);
        chk("difference", difference, e[W-1:0]);
        chk("borrow", borrow, e[W]);
        chk_ovf("overflow", e[W+1]);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready_low", in_ready, 0);
            chk("hold_difference", difference, e[W-1:0]);
            chk("hold_borrow", borrow, e[W]);
            chk_ovf("hold_overflow", e[W+1]);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_idle_in_ready", in_ready, 1);
        chk("release_out_valid_low", out_valid, 0);
        chk("idle_keeps_diff", difference, e[W-1:0]);
        prev_diff = e[W-1:0];
        prev_brw  = e[W];
        prev_ovf  = e[W+1];
    endtask

    initial begin
        logic [W+1:0] q[$];
        logic [W+1:0] e;
        int last_acc;
        int n_acc;
        int spin;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        prev_diff = '0; prev_brw = 1'b0; prev_ovf = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_difference", difference, 0);
        chk("reset_borrow", borrow, 0);
        chk_ovf("reset_overflow", 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        run_op(8'h35, 8'h12, 1'b0, 0);
        chk("dir_35_12", difference, 8'h23);
        run_op(8'h00, 8'h01, 1'b0, 0);
        chk("dir_00_01", {borrow, difference}, 9'h1FF);
        run_op(8'h10, 8'h0F, 1'b1, 0);
        chk("dir_10_0F_b1", {borrow, difference}, 9'h000);
        run_op(8'hA7, 8'h5C, 1'b1, 5);
`ifdef SERIAL_SUB_OVF_EN
        run_op(8'h80, 8'h01, 1'b0, 0);
        chk("ovf_80_01", {overflow, difference}, 9'h17F);
        run_op(8'h05, 8'h03, 1'b0, 0);
        chk("ovf_05_03", overflow, 0);
`endif

        // Reset asserted while bit 4 is about to be processed.
        in_valid = 1'b1; a = 8'h35; b = 8'h12; bin = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_difference", difference, 0);
        chk("abort_borrow", borrow, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_no_valid", out_valid, 0);
            chk("abort_diff_zero", difference, 0);
        end
        prev_diff = '0; prev_brw = 1'b0; prev_ovf = 1'b0;
        run_op(8'h09, 8'h03, 1'b0, 0);
        chk("after_abort_09_03", difference, 8'h06);

        // Randomized operations with random downstream stall.
        for (int i = 0; i < 10; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

        // Back-to-back with out_ready tied high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        last_acc = -1;
        n_acc = 0;
        for (int c = 0; c < 80; c++) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("b2b_unexpected_result", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("b2b_difference", difference, e[W-1:0]);
                    chk("b2b_borrow", borrow, e[W]);
                    chk_ovf("b2b_overflow", e[W+1]);
                end
            end
            if (in_ready) begin
                q.push_back(model(a, b, bin));
                if (last_acc >= 0) chk("b2b_interval", cyc - last_acc, W + 2);
                last_acc = cyc;
                n_acc++;
            end else begin
                a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("b2b_accept_count_ok", n_acc >= 6, 1);
        spin = 0;
        while (q.size() != 0 && spin < 40) begin
            if (out_valid) begin
                e = q.pop_front();
                chk("b2b_drain_difference", difference, e[W-1:0]);
                chk("b2b_drain_borrow", borrow, e[W]);
            end
            @(negedge clk);
            spin++;
        end
        chk("b2b_all_results", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge active.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  the operands and borrow-in are presented.
REQ-005 SHALL have port in_ready  output  1  the block can accept operands.
REQ-006 SHALL have port a  input  WIDTH  minuend.
REQ-007 SHALL have port b  input  WIDTH  subtrahend.
REQ-008 SHALL have port bin  input  1  borrow-in.
REQ-009 SHALL have port out_valid  output  1  the result is valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-011 SHALL have port difference  output  WIDTH  a - b - bin, modulo 2^WIDTH.
REQ-012 SHALL have port borrow  output  1  borrow out of the MSB.
REQ-013 SHALL have port overflow  output  1  signed overflow flag (present only under SERIAL_SUB_OVF_EN).

Function
REQ-014 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-016 SHALL, on an edge with in_valid and in_ready both high, capture a, b and bin, clear the bit counter and enter RUN.
REQ-017 SHALL ignore in_valid while in RUN or DONE.
REQ-018 SHALL process one bit per cycle in RUN, LSB first, using one full-subtractor stage:
- operands: current a-bit, b-bit and the registered borrow;
- the difference bit shifts into the result register from the MSB end;
- the borrow register updates to the stage borrow-out;
- the counter increments.
REQ-019 SHALL leave RUN for DONE on the edge that processes bit WIDTH-1.
REQ-020 SHALL assert out_valid exactly WIDTH cycles after the accepting edge.
REQ-021 SHALL hold difference, borrow and overflow stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-022 SHALL return to IDLE on an edge with out_valid and out_ready both high; accepting a new operation in that same cycle is not allowed, and in_ready rises the cycle after.
REQ-023 SHALL keep the last result on difference, borrow and overflow while in IDLE and RUN, until the next DONE.
REQ-024 SHALL treat out_ready high in DONE on the first cycle as a valid handshake, giving a minimum issue interval of WIDTH+2 cycles.
REQ-025 SHALL make borrow equal to 1 exactly when the unsigned value a < b + bin.

Reset
REQ-026 SHALL, while rst_n=0, force:
- the FSM to IDLE;
- the counter, the shift registers and the borrow register to 0;
- difference=0, borrow=0, overflow=0, out_valid=0 and in_ready=1.
REQ-027 SHALL, when rst_n asserts mid-RUN or in DONE, abandon the operation with no result produced; the first edge after deassertion sees IDLE.

Configuration
REQ-028 SHALL, when macro SERIAL_SUB_OVF_EN is defined, provide port overflow, registered on the bit WIDTH-1 edge as (borrow into MSB) XOR (borrow out of MSB).
REQ-029 SHALL, when SERIAL_SUB_OVF_EN is undefined, omit the overflow port and its logic; all other behaviour is identical.

Structure
REQ-030 SHALL take the FSM state enumeration (IDLE/RUN/DONE) and the default WIDTH constant from the shared package serial_sub_pkg.
REQ-031 SHALL instantiate the existing full_subtractor module as its single bit-slice sub-module, not re-implement it inline.

Verification (WIDTH=8)
REQ-032 SHALL cover: a=0x35, b=0x12, bin=0 -> difference=0x23, borrow=0, out_valid exactly 8 cycles after accept.
REQ-033 SHALL cover: a=0x00, b=0x01, bin=0 -> difference=0xFF, borrow=1; and a=0x10, b=0x0F, bin=1 -> difference=0x00, borrow=0.
REQ-034 SHALL cover: out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored; release -> IDLE on the next edge.
REQ-035 SHALL cover: rst_n pulsed low at bit 4 of 0x35-0x12 -> out_valid never asserts, outputs=0; a new 0x09-0x03 afterwards -> 0x06.
REQ-036 SHALL cover, with SERIAL_SUB_OVF_EN: 0x80-0x01 -> 0x7F, overflow=1; 0x05-0x03 -> overflow=0.
REQ-037 SHALL cover back-to-back operations with out_ready tied high -> consecutive accepts exactly 10 cycles apart.
